// File: rtl/feistel_cbc_decrypt_if.sv
// Block-stream bus for the Feistel CBC decryptor: ciphertext and IV in, plaintext out.
interface feistel_cbc_decrypt_if;
    logic         valid_in;
    logic         first_in;
    logic [255:0] data_in;
    logic [255:0] iv;
    logic         valid_out;
    logic [255:0] data_out;

    modport master (
        output valid_in,
        output first_in,
        output data_in,
        output iv,
        input  valid_out,
        input  data_out
    );

    modport slave (
        input  valid_in,
        input  first_in,
        input  data_in,
        input  iv,
        output valid_out,
        output data_out
    );
endinterface

// File: rtl/feistel_cbc_decrypt.sv
// Fully pipelined Feistel CBC decryptor, one 256-bit block per cycle, no backpressure.
// Optional macro FEISTEL_CBC_DEC_SEQ_CHECK_EN adds a sticky seq_err output.
module feistel_cbc_decrypt #(
    parameter int ROUNDS    = 5,
    parameter int ROUND_LAT = 2,
    parameter int KEY_SIZE  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KEY_SIZE*8-1:0] main_key,
`ifdef FEISTEL_CBC_DEC_SEQ_CHECK_EN
    output logic                  seq_err,
`endif
    feistel_cbc_decrypt_if.slave  bus
);

    localparam int DEPTH = ROUNDS * ROUND_LAT;
    localparam int KW    = KEY_SIZE * 8;

    function automatic logic [127:0] rotl128(input logic [127:0] x, input int unsigned n);
        logic [127:0] res;
        if (n == 32'd0) begin
            res = x;
        end else begin
            res = (x << n) | (x >> (32'd128 - n));
        end
        return res;
    endfunction

    function automatic logic [127:0] round_f(input logic [127:0] x, input logic [127:0] k);
        logic [127:0] sum;
        sum = (x ^ k) + rotl128(x, 32'd64);
        return rotl128(sum, 32'd3);
    endfunction

    logic [127:0] key128_s;
    logic [127:0] rk_s [0:ROUNDS-1];
    logic [255:0] chain_sel_s;

    logic         stg_valid_r [0:DEPTH];
    logic [127:0] stg_l_r     [0:DEPTH];
    logic [127:0] stg_r_r     [0:DEPTH];
    logic [255:0] stg_chain_r [0:DEPTH];

    logic         nxt_valid_s [1:DEPTH];
    logic [127:0] nxt_l_s     [1:DEPTH];
    logic [127:0] nxt_r_s     [1:DEPTH];
    logic [255:0] nxt_chain_s [1:DEPTH];

    logic [255:0] last_ct_r;
    logic         have_chain_r;
    logic         xor_valid_r;
    logic [255:0] xor_data_r;
    logic         out_valid_r;
    logic [255:0] out_data_r;

    generate
        if (KW >= 128) begin : g_key_trunc
            assign key128_s = main_key[127:0];
        end else begin : g_key_ext
            assign key128_s = {{(128-KW){1'b0}}, main_key};
        end
    endgenerate

    // Round keys in encrypt order; the pipeline consumes them from the top down.
    always_comb begin
        for (int r = 0; r < ROUNDS; r++) begin
            rk_s[r] = rotl128(key128_s, (32'(8 * r)) % 32'd128) ^ {120'd0, 8'(r)};
        end
    end

    // Chain value for the block being accepted this cycle.
    always_comb begin
        if (bus.first_in || !have_chain_r) begin
            chain_sel_s = bus.iv;
        end else begin
            chain_sel_s = last_ct_r;
        end
    end

    // Next-state of each round stage: the first stage of a round computes, the rest just delay.
    always_comb begin
        int rnd;
        rnd = 0;
        for (int s = 1; s <= DEPTH; s++) begin
            nxt_valid_s[s] = stg_valid_r[s-1];
            nxt_chain_s[s] = stg_chain_r[s-1];
            if (((s - 1) % ROUND_LAT) == 0) begin
                rnd        = ROUNDS - 1 - ((s - 1) / ROUND_LAT);
                nxt_r_s[s] = stg_l_r[s-1];
                nxt_l_s[s] = stg_r_r[s-1] ^ round_f(stg_l_r[s-1], rk_s[rnd]);
            end else begin
                nxt_r_s[s] = stg_r_r[s-1];
                nxt_l_s[s] = stg_l_r[s-1];
            end
        end
    end

    // Input stage plus round stages, with the chain riding alongside each block.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= DEPTH; s++) begin
                stg_valid_r[s] <= 1'b0;
                stg_l_r[s]     <= 128'd0;
                stg_r_r[s]     <= 128'd0;
                stg_chain_r[s] <= 256'd0;
            end
        end else begin
            stg_valid_r[0] <= bus.valid_in;
            stg_l_r[0]     <= bus.data_in[255:128];
            stg_r_r[0]     <= bus.data_in[127:0];
            stg_chain_r[0] <= chain_sel_s;
            for (int s = 1; s <= DEPTH; s++) begin
                stg_valid_r[s] <= nxt_valid_s[s];
                stg_l_r[s]     <= nxt_l_s[s];
                stg_r_r[s]     <= nxt_r_s[s];
                stg_chain_r[s] <= nxt_chain_s[s];
            end
        end
    end

    // Chaining state: only accepted blocks update it, bubbles leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ct_r    <= 256'd0;
            have_chain_r <= 1'b0;
        end else if (bus.valid_in) begin
            last_ct_r    <= bus.data_in;
            have_chain_r <= 1'b1;
        end
    end

    // CBC un-chaining is registered on its own, then held in the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            xor_valid_r <= 1'b0;
            xor_data_r  <= 256'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= 256'd0;
        end else begin
            xor_valid_r <= stg_valid_r[DEPTH];
            xor_data_r  <= {stg_l_r[DEPTH], stg_r_r[DEPTH]} ^ stg_chain_r[DEPTH];
            out_valid_r <= xor_valid_r;
            out_data_r  <= xor_data_r;
        end
    end

    assign bus.valid_out = out_valid_r;
    assign bus.data_out  = out_data_r;

`ifdef FEISTEL_CBC_DEC_SEQ_CHECK_EN
    logic seq_err_r;

    // Sticky flag: a continuation block arrived with no chain to continue from.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_err_r <= 1'b0;
        end else if (bus.valid_in && !bus.first_in && !have_chain_r) begin
            seq_err_r <= 1'b1;
        end
    end

    assign seq_err = seq_err_r;
`endif

endmodule
